// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants for the iterative divider
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step on magnitudes
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor_abs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_trial;

  // The extra top bit of the trial acts as the borrow: set means "does not fit".
  assign w_rem_sh = {i_rem, i_quo[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, i_divisor_abs};

  assign o_rem = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative signed restoring divider; DIV_UNSIGNED_EN adds unsigned_op for divu
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef DIV_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             div_zero,
  output logic             busy
);

  localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : cnt_width(WIDTH);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_count;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_div_zero;

  logic             w_signed_op;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic             w_dvs_zero;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

`ifdef DIV_UNSIGNED_EN
  assign w_signed_op = ~unsigned_op;
`else
  assign w_signed_op = 1'b1;
`endif

  // Magnitude of -2^(WIDTH-1) is representable as an unsigned WIDTH-bit value.
  assign w_dvd_neg  = w_signed_op & dividend[WIDTH-1];
  assign w_dvs_neg  = w_signed_op & divisor[WIDTH-1];
  assign w_dvd_abs  = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_abs  = w_dvs_neg ? -divisor : divisor;
  assign w_dvs_zero = (divisor == '0);

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem        (r_rem),
    .i_quo        (r_quo),
    .i_divisor_abs(r_dvs),
    .o_rem        (w_rem_next),
    .o_quo        (w_quo_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_count    <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_dvs_zero) begin
              r_done     <= 1'b1;
              r_div_zero <= 1'b1;
            end else begin
              r_sign_q <= w_dvd_neg ^ w_dvs_neg;
              r_sign_r <= w_dvd_neg;
              r_quo    <= w_dvd_abs;
              r_dvs    <= w_dvs_abs;
              r_rem    <= '0;
              r_count  <= CNT_W'(WIDTH);
              r_state  <= ITER;
            end
          end
        end
        ITER: begin
          r_rem   <= w_rem_next;
          r_quo   <= w_quo_next;
          r_count <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_lo    <= r_sign_q ? -r_quo : r_quo;
          r_hi    <= r_sign_r ? -r_rem : r_rem;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign busy     = (r_state == ITER) || (r_state == FIX);

endmodule
